// File: rtl/laser_pulse_gen.sv
// ============================================================================
// Module   : laser_pulse_gen
// Purpose  : Laser trigger pulse-train generator. The pulse width, the period
//            and the pulse count are programmable. The train can be stopped
//            by abort or by reset. The registered output o_laser_pulse is the
//            signal that the safety monitors watch.
// Options  : SAFETY_INTERLOCK_EN adds i_fail_in. It forces the output low,
//            ends the train and blocks any new start.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module laser_pulse_gen #(
  parameter int CNT_W = 32,
  parameter int NUM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
`ifdef SAFETY_INTERLOCK_EN
  input  logic             i_fail_in,
`endif
  input  logic [CNT_W-1:0] i_pulse_width,
  input  logic [CNT_W-1:0] i_pulse_period,
  input  logic [NUM_W-1:0] i_pulse_num,
  output logic             o_laser_pulse,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_aborted,
  output logic             o_cfg_err,
  output logic [NUM_W-1:0] o_pulses_sent
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [NUM_W-1:0] c_NUM_ONE  = NUM_W'(1);
  localparam logic [NUM_W-1:0] c_NUM_SAT  = {NUM_W{1'b1}};

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]   r_width, w_width_nxt;
  logic [CNT_W-1:0]   r_period, w_period_nxt;
  logic [NUM_W-1:0]   r_num, w_num_nxt;
  logic [NUM_W-1:0]   r_sent, w_sent_nxt;
  logic               r_laser, w_laser_nxt;
  logic               r_done, w_done_nxt;
  logic               r_aborted, w_aborted_nxt;
  logic               r_cfg_err, w_cfg_err_nxt;
  logic               w_fail;
  logic               w_cfg_ok;
  logic               w_stop;

`ifdef SAFETY_INTERLOCK_EN
  assign w_fail = i_fail_in;
`else
  assign w_fail = 1'b0;
`endif

  assign w_cfg_ok = (i_pulse_width != '0) && (i_pulse_width < i_pulse_period);
  // The interlock and abort stop an active train. Both take priority over
  // period completion, so a train that stops this way never reports done.
  assign w_stop   = i_abort || w_fail;

  // Next-state and datapath decode for the IDLE / HIGH / LOW sequencer
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_width_nxt   = r_width;
    w_period_nxt  = r_period;
    w_num_nxt     = r_num;
    w_sent_nxt    = r_sent;
    w_laser_nxt   = r_laser;
    w_done_nxt    = 1'b0;
    w_aborted_nxt = 1'b0;
    w_cfg_err_nxt = r_cfg_err;
    case (r_state)
      S_IDLE: begin
        w_laser_nxt = 1'b0;
        if (i_start && !w_fail) begin
          if (w_cfg_ok) begin
            w_state_nxt   = S_HIGH;
            w_cnt_nxt     = c_CNT_ONE;
            w_width_nxt   = i_pulse_width;
            w_period_nxt  = i_pulse_period;
            w_num_nxt     = i_pulse_num;
            w_sent_nxt    = c_NUM_ONE;
            w_laser_nxt   = 1'b1;
            w_cfg_err_nxt = 1'b0;
          end else begin
            w_cfg_err_nxt = 1'b1;
          end
        end
      end
      S_HIGH: begin
        if (w_stop) begin
          w_state_nxt   = S_IDLE;
          w_cnt_nxt     = '0;
          w_laser_nxt   = 1'b0;
          w_aborted_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
          if (r_cnt == r_width) begin
            w_state_nxt = S_LOW;
            w_laser_nxt = 1'b0;
          end
        end
      end
      S_LOW: begin
        if (w_stop) begin
          w_state_nxt   = S_IDLE;
          w_cnt_nxt     = '0;
          w_laser_nxt   = 1'b0;
          w_aborted_nxt = 1'b1;
        end else if (r_cnt == r_period) begin
          if ((r_num != '0) && (r_sent == r_num)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            // cnt restarts at 1, so rising edges are exactly one period apart
            w_state_nxt = S_HIGH;
            w_cnt_nxt   = c_CNT_ONE;
            w_laser_nxt = 1'b1;
            if (r_sent != c_NUM_SAT) begin
              w_sent_nxt = r_sent + c_NUM_ONE;
            end
          end
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_laser_nxt = 1'b0;
      end
    endcase
  end

  // State, counters, latched configuration and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_width   <= '0;
      r_period  <= '0;
      r_num     <= '0;
      r_sent    <= '0;
      r_laser   <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_width   <= w_width_nxt;
      r_period  <= w_period_nxt;
      r_num     <= w_num_nxt;
      r_sent    <= w_sent_nxt;
      r_laser   <= w_laser_nxt;
      r_done    <= w_done_nxt;
      r_aborted <= w_aborted_nxt;
      r_cfg_err <= w_cfg_err_nxt;
    end
  end

  assign o_laser_pulse = r_laser;
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;
  assign o_aborted     = r_aborted;
  assign o_cfg_err     = r_cfg_err;
  assign o_pulses_sent = r_sent;

endmodule

`default_nettype wire
